// File: rtl/card_shoe_if.sv
// Card shoe bus: draw/shuffle requests from the master, card and deck status from the shoe.
// cardValid is a one-cycle pulse with no ready; a consumer must take cardOut in that cycle or read the held value later.
interface card_shoe_if;
  logic       getCard;
  logic       shuffle;
  logic [5:0] cardOut;
  logic       cardValid;
  logic       busy;
  logic       deckEmpty;
  logic [5:0] cardsLeft;
  logic [1:0] state_dbg;

  modport master (
    output getCard, shuffle,
    input  cardOut, cardValid, busy, deckEmpty, cardsLeft, state_dbg
  );

  modport slave (
    input  getCard, shuffle,
    output cardOut, cardValid, busy, deckEmpty, cardsLeft, state_dbg
  );
endinterface

// File: rtl/card_shoe.sv
// 52-card shoe: edge-triggered draws from a register deck, Fisher-Yates reshuffle
// driven by a free-running 16-bit LFSR.
module card_shoe (
  input  logic        clk,
  input  logic        reset,
  card_shoe_if.slave  bus
);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    SHUFFLE = 2'd1,
    EMPTY   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [5:0]  deck [52];
  logic [5:0]  ptr;
  logic [5:0]  idx;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        getCard_q;
  logic [5:0]  card_out;
  logic        card_valid;
  logic        deck_empty;
  logic [5:0]  cand;
  logic        draw_edge;
  logic        draw_ev;
  logic        start_shuf;
  logic        do_swap;

  function automatic logic [5:0] init_code(input int k);
    logic [1:0] s;
    logic [3:0] r;
    s = 2'(k / 13);
    r = 4'((k % 13) + 1);
    return {s, r};
  endfunction

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand      = lfsr[5:0];
  assign draw_edge = bus.getCard & ~getCard_q;

  always_comb begin
    state_next = state;
    draw_ev    = 1'b0;
    start_shuf = 1'b0;
    do_swap    = 1'b0;
    case (state)
      READY, EMPTY: begin
        // Shuffle takes priority over a coincident draw edge.
        if (bus.shuffle) begin
          start_shuf = 1'b1;
          state_next = SHUFFLE;
        end else if (draw_edge) begin
          draw_ev = 1'b1;
          if (state == READY && ptr == 6'd51) state_next = EMPTY;
        end
      end
      SHUFFLE: begin
        if (cand <= idx) begin
          do_swap = 1'b1;
          if (idx == 6'd1) state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= READY;
      ptr        <= 6'd0;
      idx        <= 6'd51;
      lfsr       <= 16'hACE1;
      getCard_q  <= 1'b0;
      card_out   <= 6'd0;
      card_valid <= 1'b0;
      deck_empty <= 1'b0;
      for (int k = 0; k < 52; k++) deck[k] <= init_code(k);
    end else begin
      state      <= state_next;
      lfsr       <= {lfsr[14:0], lfsr_fb};
      getCard_q  <= bus.getCard;
      card_valid <= draw_ev;
      if (start_shuf) begin
        ptr <= 6'd0;
        idx <= 6'd51;
      end
      if (draw_ev) begin
        if (state == EMPTY) begin
          card_out <= 6'd0;
        end else begin
          card_out <= deck[ptr];
          ptr      <= ptr + 6'd1;
          if (ptr == 6'd51) deck_empty <= 1'b1;
        end
      end
      // When cand == idx both writes carry the same value, so the swap is a no-op.
      if (do_swap) begin
        deck[idx]  <= deck[cand];
        deck[cand] <= deck[idx];
        idx        <= idx - 6'd1;
        if (idx == 6'd1) deck_empty <= 1'b0;
      end
    end
  end

  assign bus.cardOut   = card_out;
  assign bus.cardValid = card_valid;
  assign bus.busy      = (state == SHUFFLE);
  assign bus.deckEmpty = deck_empty;
  assign bus.cardsLeft = 6'd52 - ptr;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: ordered draw, exhaustion, shuffle permutation,
// level hold, shuffle/draw collision and reset during a shuffle.
module tb_card_shoe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [5:0] exp_q [$];

  card_shoe_if shoe ();

  card_shoe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (shoe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one getCard pulse, returns what the shoe showed one edge later
  task automatic draw(output logic valid, output logic [5:0] card);
    @(negedge clk);
    shoe.getCard = 1'b1;
    @(negedge clk);
    valid = shoe.cardValid;
    card  = shoe.cardOut;
    shoe.getCard = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_ordered(input int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] s;
      logic [3:0] r;
      s = 2'(k / 13);
      r = 4'((k % 13) + 1);
      exp_q.push_back({s, r});
    end
  endtask

  initial begin
    logic       v;
    logic [5:0] c;
    logic [63:0] seen;
    int         busy_cycles;
    int         stray_valid;
    int         distinct;
    int         pulses;

    checks = 0;
    errors = 0;
    shoe.getCard = 1'b0;
    shoe.shuffle = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_cardOut",   32'(shoe.cardOut),   32'h0);
    chk("rst_cardValid", 32'(shoe.cardValid), 32'h0);
    chk("rst_busy",      32'(shoe.busy),      32'h0);
    chk("rst_deckEmpty", 32'(shoe.deckEmpty), 32'h0);
    chk("rst_cardsLeft", 32'(shoe.cardsLeft), 32'd52);
    reset = 1'b0;
    @(negedge clk);

    // ordered draw of the whole deck
    push_ordered(52);
    for (int n = 0; n < 52; n++) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      draw(v, c);
      chk("ord_valid", 32'(v), 32'h1);
      chk("ord_card",  32'(c), 32'(e));
      chk("ord_left",  32'(shoe.cardsLeft), 32'(51 - n));
      chk("ord_empty", 32'(shoe.deckEmpty), (n == 51) ? 32'h1 : 32'h0);
    end

    // exhaustion
    draw(v, c);
    chk("exh_valid", 32'(v), 32'h1);
    chk("exh_card",  32'(c), 32'h0);
    chk("exh_empty", 32'(shoe.deckEmpty), 32'h1);
    chk("exh_left",  32'(shoe.cardsLeft), 32'h0);

    // shuffle from EMPTY, poking getCard while busy
    @(negedge clk);
    shoe.shuffle = 1'b1;
    @(negedge clk);
    shoe.shuffle = 1'b0;
    busy_cycles = 0;
    stray_valid = 0;
    while (shoe.busy === 1'b1 && busy_cycles < 5000) begin
      busy_cycles++;
      if (shoe.cardValid === 1'b1) stray_valid++;
      shoe.getCard = ~shoe.getCard;
      @(negedge clk);
    end
    if (shoe.cardValid === 1'b1) stray_valid++;
    shoe.getCard = 1'b0;
    chk("shuf_done",        32'(shoe.busy), 32'h0);
    chk("shuf_min_cycles",  32'(busy_cycles >= 51), 32'h1);
    chk("shuf_no_valid",    32'(stray_valid), 32'h0);
    chk("shuf_empty_clear", 32'(shoe.deckEmpty), 32'h0);
    chk("shuf_left",        32'(shoe.cardsLeft), 32'd52);

    seen = '0;
    distinct = 0;
    for (int n = 0; n < 52; n++) begin
      draw(v, c);
      chk("perm_valid", 32'(v), 32'h1);
      chk("perm_code_ok",
          32'(c[3:0] >= 4'd1 && c[3:0] <= 4'd13 && seen[c] == 1'b0), 32'h1);
      if (c[3:0] >= 4'd1 && c[3:0] <= 4'd13 && !seen[c]) distinct++;
      seen[c] = 1'b1;
    end
    chk("perm_cover", 32'(distinct), 32'd52);
    chk("perm_empty", 32'(shoe.deckEmpty), 32'h1);

    // level hold: reshuffle, then hold getCard for 10 cycles
    @(negedge clk);
    shoe.shuffle = 1'b1;
    @(negedge clk);
    shoe.shuffle = 1'b0;
    busy_cycles = 0;
    while (shoe.busy === 1'b1 && busy_cycles < 5000) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("hold_ready", 32'(shoe.busy), 32'h0);
    pulses = 0;
    shoe.getCard = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (shoe.cardValid === 1'b1) pulses++;
    end
    shoe.getCard = 1'b0;
    @(negedge clk);
    if (shoe.cardValid === 1'b1) pulses++;
    chk("hold_pulses", 32'(pulses), 32'h1);
    chk("hold_left",   32'(shoe.cardsLeft), 32'd51);

    // collision: shuffle and a getCard edge together
    shoe.shuffle = 1'b1;
    shoe.getCard = 1'b1;
    @(negedge clk);
    shoe.shuffle = 1'b0;
    chk("coll_valid", 32'(shoe.cardValid), 32'h0);
    chk("coll_busy",  32'(shoe.busy), 32'h1);
    chk("coll_left",  32'(shoe.cardsLeft), 32'd52);

    // reset in the middle of that shuffle
    repeat (5) @(negedge clk);
    chk("midrst_pre_busy", 32'(shoe.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy",  32'(shoe.busy), 32'h0);
    chk("midrst_left",  32'(shoe.cardsLeft), 32'd52);
    chk("midrst_card",  32'(shoe.cardOut), 32'h0);
    shoe.getCard = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    push_ordered(14);
    for (int n = 0; n < 14; n++) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      draw(v, c);
      chk("midrst_valid", 32'(v), 32'h1);
      chk("midrst_order", 32'(c), 32'(e));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are clk and reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- getCard  in  1  draw request, level; one draw per rising edge of getCard
- shuffle  in  1  single-cycle pulse; starts a reshuffle of the full 52-card deck
- cardOut  out  6  {suit[1:0], rank[3:0]}; rank 1=Ace through 13=King; 6'b0 = no card
- cardValid  out  1  one-cycle pulse; cardOut updated this cycle
- busy  out  1  high while a shuffle is in progress
- deckEmpty  out  1  high when all 52 cards have been drawn
- cardsLeft  out  6  undrawn cards remaining, 0..52

Function
REQ-003 The block SHALL hold the deck as 52 six-bit entries deck[0..51] and a 6-bit draw pointer ptr.
REQ-004 The block SHALL run a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, that advances every clk in every state.
REQ-005 The FSM SHALL have states READY, SHUFFLE and EMPTY.
REQ-006 Edge detect: getCard SHALL be registered to getCard_q; a draw event is getCard=1 and getCard_q=0 at a clk edge.
REQ-007 In READY, a draw event SHALL, at that same edge:
- load cardOut with deck[ptr]
- pulse cardValid for one cycle
- increment ptr
REQ-008 cardOut SHALL hold its value between draws.
REQ-009 Holding getCard high for any number of cycles SHALL produce exactly one draw.
REQ-010 When ptr becomes 52, the FSM SHALL enter EMPTY and assert deckEmpty.
REQ-011 In EMPTY, a draw event SHALL load cardOut with 6'b0 and pulse cardValid; deckEmpty SHALL stay 1 and ptr SHALL stay 52.
REQ-012 cardsLeft SHALL equal 52 - ptr at all times.
REQ-013 A shuffle pulse in READY or EMPTY SHALL:
- enter SHUFFLE
- set busy
- set index i=51
- clear ptr to 0
REQ-014 SHUFFLE SHALL perform a Fisher-Yates pass over whatever permutation the deck currently holds:
- each cycle, take candidate j = lfsr[5:0]
- if j <= i: swap deck[i] and deck[j] in that cycle, then decrement i
- if j > i: reject the candidate and retry next cycle, i unchanged
REQ-015 When a swap completes at i=1, the FSM SHALL return to READY, deassert busy and clear deckEmpty.
REQ-016 A shuffle pass SHALL take at least 51 cycles; its duration is data-dependent.
REQ-017 getCard events during SHUFFLE SHALL be ignored: cardOut unchanged, no cardValid, and no deferred draw.
REQ-018 A shuffle pulse during SHUFFLE SHALL be ignored.
REQ-019 If shuffle and a draw event occur in the same cycle in READY or EMPTY, shuffle SHALL win and no draw occurs.
REQ-020 The deck SHALL always be a permutation of the 52 distinct codes {s, r} with s in 0..3 and r in 1..13; no code is ever duplicated or lost.

Reset
REQ-021 Reset SHALL, asynchronously and at any time including mid-shuffle:
- load deck[k] = {k/13, (k mod 13)+1}
- set ptr=0 and state=READY
- set lfsr=16'hACE1 and getCard_q=0
REQ-022 Reset SHALL force cardOut=0, cardValid=0, busy=0, deckEmpty=0 and cardsLeft=52.

Verification
REQ-023 Ordered draw: reset, then 52 getCard pulses with no shuffle -> cardOut sequence is 6'h01..6'h0D, 6'h11..6'h1D, 6'h21..6'h2D, 6'h31..6'h3D; cardsLeft counts 51..0; deckEmpty rises with the 52nd cardValid.
REQ-024 Exhaustion: a 53rd getCard pulse -> cardOut=6'b0 with a cardValid pulse; deckEmpty=1; cardsLeft=0.
REQ-025 Shuffle permutation: shuffle pulse -> busy high for at least 51 cycles, then low; the next 52 draws are all distinct valid codes covering all 52 cards; getCard pulses while busy produce no cardValid.
REQ-026 Level hold: getCard held high for 10 cycles -> exactly one cardValid pulse and cardsLeft decremented by 1.
REQ-027 Collision: shuffle and a getCard rising edge in the same cycle -> no cardValid, busy=1, cardsLeft=52.
REQ-028 Reset mid-shuffle: assert reset during SHUFFLE -> busy=0 immediately; the next draws follow the ordered sequence of REQ-023.
